// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters with stat_clr.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 5
`ifdef ALU_ARB_STATS_EN
  , parameter int unsigned STAT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cf,
  input  logic             alu_sf,
  input  logic             alu_zf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cf,
  output logic             rsp_sf,
  output logic             rsp_zf,
  output logic             busy
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_grant;
  logic   grant;
  logic   accept;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          req0_ready = ~grant;
          req1_ready = grant;
          state_nxt  = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand launch on the handshake, result capture one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= 1'b0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_cf     <= 1'b0;
      rsp_sf     <= 1'b0;
      rsp_zf     <= 1'b0;
    end else begin
      if (accept) begin
        alu_a      <= grant ? req1_a : req0_a;
        alu_b      <= grant ? req1_b : req0_b;
        alu_op     <= grant ? req1_op : req0_op;
        rsp_id     <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_cf     <= alu_cf;
        rsp_sf     <= alu_sf;
        rsp_zf     <= alu_zf;
        rsp_valid  <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef ALU_ARB_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Saturating grant counters; a clear wins over a coincident grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (stat_clr) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && grant_cnt0 != STAT_MAX) begin
        grant_cnt0 <= grant_cnt0 + STAT_W'(1);
      end
      if (req1_ready && grant_cnt1 != STAT_MAX) begin
        grant_cnt1 <= grant_cnt1 + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed steps plus a randomized phase
// checked against a transaction-level model. Stats checks run when ALU_ARB_STATS_EN is defined.
module tb_alu_share_arbiter;

  logic       clk;
  logic       reset;
  logic       req0_valid, req0_ready, req0_op;
  logic [4:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_op;
  logic [4:0] req1_a, req1_b;
  logic [4:0] alu_a, alu_b, alu_result;
  logic       alu_op, alu_cf, alu_sf, alu_zf;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [4:0] rsp_result;
  logic       rsp_cf, rsp_sf, rsp_zf;
  logic       busy;
`ifdef ALU_ARB_STATS_EN
  logic       stat_clr;
  logic [7:0] grant_cnt0, grant_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  alu_share_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_cf     (alu_cf),
    .alu_sf     (alu_sf),
    .alu_zf     (alu_zf),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_cf     (rsp_cf),
    .rsp_sf     (rsp_sf),
    .rsp_zf     (rsp_zf),
    .busy       (busy)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU reference: returns {cf, sf, zf, result}; subtract sets cf on borrow.
  function automatic logic [7:0] alu_ref(input logic [4:0] a, input logic [4:0] b, input logic op);
    int         r;
    logic       cf;
    logic [4:0] res;
    if (op == 1'b0) begin
      r  = int'(a) + int'(b);
      cf = (r > 31);
    end else begin
      r  = int'(a) - int'(b);
      cf = (r < 0);
    end
    res = 5'((r + 32) % 32);
    return {cf, res[4], (res == 5'd0), res};
  endfunction

  always_comb {alu_cf, alu_sf, alu_zf, alu_result} = alu_ref(alu_a, alu_b, alu_op);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Transaction-level model: one outstanding op, response two cycles after acceptance.
  bit         m_pend;
  int         m_age;
  bit         m_last;
  bit         t_id;
  logic [4:0] t_a, t_b;
  logic       t_op;
  bit         acc0, acc1;
`ifdef ALU_ARB_STATS_EN
  int         m_cnt0, m_cnt1;
`endif

  task automatic model_reset();
    m_pend = 1'b0;
    m_age  = 0;
    m_last = 1'b1;
    acc0   = 1'b0;
    acc1   = 1'b0;
`ifdef ALU_ARB_STATS_EN
    m_cnt0 = 0;
    m_cnt1 = 0;
`endif
  endtask

  task automatic model_cycle();
    bit         e0, e1;
    logic [7:0] r;
    e0 = !m_pend && (req0_valid === 1'b1) && ((req1_valid !== 1'b1) || m_last);
    e1 = !m_pend && (req1_valid === 1'b1) && ((req0_valid !== 1'b1) || !m_last);
    chk("ready0", 32'(req0_ready), 32'(e0));
    chk("ready1", 32'(req1_ready), 32'(e1));
    chk("busy", 32'(busy), 32'(m_pend));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_pend && m_age >= 2));
    if (m_pend) begin
      chk("alu_a", 32'(alu_a), 32'(t_a));
      chk("alu_b", 32'(alu_b), 32'(t_b));
      chk("alu_op", 32'(alu_op), 32'(t_op));
    end
    if (m_pend && m_age >= 2) begin
      r = alu_ref(t_a, t_b, t_op);
      chk("rsp_id", 32'(rsp_id), 32'(t_id));
      chk("rsp_result", 32'(rsp_result), 32'(r[4:0]));
      chk("rsp_cf", 32'(rsp_cf), 32'(r[7]));
      chk("rsp_sf", 32'(rsp_sf), 32'(r[6]));
      chk("rsp_zf", 32'(rsp_zf), 32'(r[5]));
    end
`ifdef ALU_ARB_STATS_EN
    chk("grant_cnt0", 32'(grant_cnt0), 32'(m_cnt0));
    chk("grant_cnt1", 32'(grant_cnt1), 32'(m_cnt1));
    if (stat_clr) begin
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else begin
      if (e0 && m_cnt0 < 255) m_cnt0++;
      if (e1 && m_cnt1 < 255) m_cnt1++;
    end
`endif
    acc0 = e0;
    acc1 = e1;
    if (m_pend) begin
      if (m_age >= 2 && rsp_ready) m_pend = 1'b0;
      else if (m_age < 2) m_age++;
    end else if (e0 || e1) begin
      m_pend = 1'b1;
      m_age  = 1;
      t_id   = e1;
      t_a    = e1 ? req1_a : req0_a;
      t_b    = e1 ? req1_b : req0_b;
      t_op   = e1 ? req1_op : req0_op;
      m_last = e1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    repeat (4) begin
      tick();
      adv();
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_alu_a"}, 32'(alu_a), 0);
    chk({tag, "_alu_b"}, 32'(alu_b), 0);
    chk({tag, "_alu_op"}, 32'(alu_op), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
    chk({tag, "_rsp_result"}, 32'(rsp_result), 0);
    chk({tag, "_rsp_flags"}, 32'({rsp_cf, rsp_sf, rsp_zf}), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    bit         hold0, hold1;
    int         exp_id, nresp, n;
    logic [4:0] snap;

    reset = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 1'b0;
    rsp_ready = 1'b0;
`ifdef ALU_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    #1 reset = 1'b1;
    #2;
    check_reset_values("por");
    chk("por_ready", 32'({req0_ready, req1_ready}), 0);
    adv();
    reset = 1'b0;
    model_reset();

    // Single request: 3 + 4.
    req0_valid = 1'b1; req0_a = 5'd3; req0_b = 5'd4; req0_op = 1'b0; rsp_ready = 1'b1;
    tick();
    chk("single_ready0", 32'(req0_ready), 1);
    adv();
    req0_valid = 1'b0;
    tick();
    chk("single_exec_busy", 32'(busy), 1);
    chk("single_exec_ready0", 32'(req0_ready), 0);
    adv();
    tick();
    chk("single_rsp_valid", 32'(rsp_valid), 1);
    chk("single_rsp_id", 32'(rsp_id), 0);
    chk("single_result", 32'(rsp_result), 7);
    chk("single_cf_zf", 32'({rsp_cf, rsp_zf}), 0);
    adv();
    tick();
    chk("single_idle_busy", 32'(busy), 0);
    adv();
    flush();

    // Tie: both valid continuously; requester 0 served last, so requester 1 goes first.
    req0_valid = 1'b1; req0_a = 5'd5;  req0_b = 5'd5; req0_op = 1'b1;
    req1_valid = 1'b1; req1_a = 5'd31; req1_b = 5'd1; req1_op = 1'b0;
    rsp_ready = 1'b1;
    exp_id = 1;
    nresp = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid) begin
        chk("tie_id", 32'(rsp_id), 32'(exp_id));
        chk("tie_result", 32'(rsp_result), 0);
        chk("tie_cf", 32'(rsp_cf), 32'(exp_id));
        chk("tie_zf", 32'(rsp_zf), 1);
        exp_id = 1 - exp_id;
        nresp++;
      end
      adv();
    end
    chk("tie_count", 32'(nresp), 4);
    flush();

    // Back-pressure: 10 - 9 held for 10 cycles while requester 1 waits.
    req0_valid = 1'b1; req0_a = 5'd10; req0_b = 5'd9; req0_op = 1'b1;
    rsp_ready = 1'b0;
    tick();
    chk("bp_accept", 32'(req0_ready), 1);
    adv();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 5'd2; req1_b = 5'd7; req1_op = 1'b1;
    tick();
    n = 0;
    while (!rsp_valid && n < 5) begin
      adv();
      tick();
      n++;
    end
    chk("bp_wait_rsp", 32'(rsp_valid), 1);
    snap = rsp_result;
    chk("bp_result", 32'(snap), 1);
    for (int i = 0; i < 10; i++) begin
      adv();
      tick();
      chk("bp_stable_result", 32'(rsp_result), 1);
      chk("bp_stable_valid", 32'(rsp_valid), 1);
      chk("bp_stable_id", 32'(rsp_id), 0);
      chk("bp_readys", 32'({req0_ready, req1_ready}), 0);
    end
    adv();
    rsp_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(rsp_valid), 1);
    adv();
    tick();
    chk("bp_idle_busy", 32'(busy), 0);
    chk("bp_idle_ready1", 32'(req1_ready), 1);
    adv();
    req1_valid = 1'b0;
    flush();

    // Reset during EXEC discards the operation.
    req0_valid = 1'b1; req0_a = 5'd7; req0_b = 5'd8; req0_op = 1'b0;
    tick();
    adv();
    req0_valid = 1'b0;
    tick();
    chk("mid_exec_busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_reset_values("mid");
    adv();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_reset_no_rsp", 32'(rsp_valid), 0);
      adv();
    end
    req0_valid = 1'b1; req0_a = 5'd1; req0_b = 5'd2; req0_op = 1'b0;
    req1_valid = 1'b1; req1_a = 5'd4; req1_b = 5'd4; req1_op = 1'b1;
    tick();
    chk("reset_tie_ready0", 32'(req0_ready), 1);
    chk("reset_tie_ready1", 32'(req1_ready), 0);
    adv();
    req0_valid = 1'b0;
    tick();
    adv();
    flush();

    // Randomized traffic; requesters hold until accepted, occasionally withdraw.
    hold0 = 1'b0;
    hold1 = 1'b0;
    acc0  = 1'b0;
    acc1  = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (acc0) hold0 = 1'b0;
      if (acc1) hold1 = 1'b0;
      if (!hold0 && $urandom_range(0, 2) != 0) begin
        hold0 = 1'b1;
        req0_a = 5'($urandom); req0_b = 5'($urandom); req0_op = 1'($urandom);
      end else if (hold0 && $urandom_range(0, 19) == 0) begin
        hold0 = 1'b0;
      end
      if (!hold1 && $urandom_range(0, 2) != 0) begin
        hold1 = 1'b1;
        req1_a = 5'($urandom); req1_b = 5'($urandom); req1_op = 1'($urandom);
      end else if (hold1 && $urandom_range(0, 19) == 0) begin
        hold1 = 1'b0;
      end
      req0_valid = hold0;
      req1_valid = hold1;
      rsp_ready  = ($urandom_range(0, 3) != 0);
      tick();
      adv();
    end
    flush();

`ifdef ALU_ARB_STATS_EN
    // Saturation after 300 grants, then clear coinciding with a grant.
    req0_valid = 1'b1; req0_a = 5'd9; req0_b = 5'd3; req0_op = 1'b1;
    rsp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 1500 && n < 300; c++) begin
      tick();
      if (acc0) n++;
      adv();
    end
    chk("stat_grants_done", 32'(n), 300);
    flush();
    chk("stat_cnt0_sat", 32'(grant_cnt0), 255);
    req0_valid = 1'b1;
    stat_clr = 1'b1;
    tick();
    chk("stat_clr_grant", 32'(req0_ready), 1);
    adv();
    stat_clr = 1'b0;
    req0_valid = 1'b0;
    tick();
    chk("stat_cnt0_cleared", 32'(grant_cnt0), 0);
    adv();
    flush();
    req1_valid = 1'b1;
    tick();
    adv();
    req1_valid = 1'b0;
    flush();
    chk("stat_cnt1_one", 32'(grant_cnt1), 1);
    chk("stat_cnt0_still0", 32'(grant_cnt0), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
